// File: rtl/fft_io_pkg.sv
// Shared definitions for the FFT result byte stream (serializer now, deserializer later).
package fft_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  // Bytes needed to carry one word, rounding partial bytes up.
  function automatic int bpw_f(input int word_size);
    return (word_size + 7) / 8;
  endfunction

  // Words sent per bin: real only, or real followed by imaginary.
  function automatic int wpb_f(input int include_im);
    return 1 + include_im;
  endfunction

  // Total bytes in one frame, including the optional header byte.
  function automatic int total_f(input int fft_size, input int word_size,
                                 input int include_im, input int header_en);
    return header_en + fft_size * wpb_f(include_im) * bpw_f(word_size);
  endfunction

endpackage

// File: rtl/fft_byte_select.sv
// Maps a frame byte index onto the matching byte of the captured snapshot.
module fft_byte_select
  import fft_io_pkg::*;
#(
  parameter int         FFT_SIZE    = 16,
  parameter int         WORD_SIZE   = 16,
  parameter int         INCLUDE_IM  = 0,
  parameter int         MSB_FIRST   = 0,
  parameter int         HEADER_EN   = 0,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
  parameter int         IDX_W       = 6
) (
  input  logic [FFT_SIZE*WORD_SIZE-1:0] re_snap,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] im_snap,
  input  logic [IDX_W-1:0]              index,
  output logic [7:0]                    byte_out
);

  localparam int BPW   = bpw_f(WORD_SIZE);
  localparam int WPB   = wpb_f(INCLUDE_IM);
  localparam int EXT_W = BPW * 8;

  int                   data_idx;
  int                   bin;
  int                   rem;
  int                   word_sel;
  int                   byte_in_word;
  int                   byte_pos;
  logic [WORD_SIZE-1:0] word;
  logic [EXT_W-1:0]     ext;

  // Decode index into bin/word/byte, sign-extend the word, then pick the byte.
  always_comb begin
    data_idx = int'(index) - HEADER_EN;
    if (data_idx < 0) begin
      data_idx = 0;
    end
    bin          = data_idx / (WPB * BPW);
    rem          = data_idx % (WPB * BPW);
    word_sel     = rem / BPW;
    byte_in_word = rem % BPW;
    byte_pos     = (MSB_FIRST != 0) ? (BPW - 1 - byte_in_word) : byte_in_word;

    word = '0;
    for (int k = 0; k < FFT_SIZE; k++) begin
      if (k == bin) begin
        word = (word_sel == 1) ? im_snap[k*WORD_SIZE +: WORD_SIZE]
                               : re_snap[k*WORD_SIZE +: WORD_SIZE];
      end
    end

    ext                  = {EXT_W{word[WORD_SIZE-1]}};
    ext[WORD_SIZE-1:0]   = word;
    byte_out             = ext[byte_pos*8 +: 8];

    if (HEADER_EN != 0 && index == '0) begin
      byte_out = HEADER_BYTE;
    end
  end

endmodule

// File: rtl/fft_result_serializer.sv
// Snapshots one FFT frame and streams it byte-by-byte through a start/done UART handshake.
module fft_result_serializer
  import fft_io_pkg::*;
#(
  parameter int         FFT_SIZE    = 16,
  parameter int         WORD_SIZE   = 16,
  parameter int         INCLUDE_IM  = 0,
  parameter int         MSB_FIRST   = 0,
  parameter int         HEADER_EN   = 0,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] i_re_bus,
  input  logic [FFT_SIZE*WORD_SIZE-1:0] i_im_bus,
  input  logic                          i_capture,
  input  logic                          i_tx_done,
  output logic                          o_tx_start,
  output logic [7:0]                    o_tx_byte,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic                          o_overrun
);

  localparam int TOTAL = total_f(FFT_SIZE, WORD_SIZE, INCLUDE_IM, HEADER_EN);
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  state_t                        state;
  state_t                        next_state;
  logic [IDX_W-1:0]              index;
  logic [FFT_SIZE*WORD_SIZE-1:0] re_snap;
  logic [FFT_SIZE*WORD_SIZE-1:0] im_snap;
  logic                          load;
  logic                          advance;
  logic                          finish;
  logic                          set_overrun;
  logic                          frame_done_q;
  logic                          overrun_q;
  logic [7:0]                    sel_byte;

  fft_byte_select #(
    .FFT_SIZE    (FFT_SIZE),
    .WORD_SIZE   (WORD_SIZE),
    .INCLUDE_IM  (INCLUDE_IM),
    .MSB_FIRST   (MSB_FIRST),
    .HEADER_EN   (HEADER_EN),
    .HEADER_BYTE (HEADER_BYTE),
    .IDX_W       (IDX_W)
  ) u_byte_select (
    .re_snap  (re_snap),
    .im_snap  (im_snap),
    .index    (index),
    .byte_out (sel_byte)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Snapshot, byte index, frame-done pulse and sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      index        <= '0;
      re_snap      <= '0;
      im_snap      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= finish;
      if (set_overrun) begin
        overrun_q <= 1'b1;
      end
      if (load) begin
        re_snap <= i_re_bus;
        im_snap <= i_im_bus;
        index   <= '0;
      end else if (advance) begin
        index <= index + IDX_W'(1);
      end
    end
  end

  // Next state, datapath controls and handshake outputs; a capture that lands on the final done starts the next frame.
  always_comb begin
    next_state   = state;
    load         = 1'b0;
    advance      = 1'b0;
    finish       = 1'b0;
    set_overrun  = 1'b0;
    o_tx_start   = 1'b0;
    o_tx_byte    = 8'h00;
    o_busy       = (state != IDLE);
    o_frame_done = frame_done_q;
    o_overrun    = overrun_q;
    case (state)
      IDLE: begin
        if (i_capture) begin
          load       = 1'b1;
          next_state = START;
        end
      end
      START: begin
        o_tx_start = 1'b1;
        o_tx_byte  = sel_byte;
        next_state = WAIT;
        if (i_capture) begin
          set_overrun = 1'b1;
        end
      end
      WAIT: begin
        o_tx_byte = sel_byte;
        if (i_tx_done && index == LAST_IDX) begin
          finish = 1'b1;
          if (i_capture) begin
            load       = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end else begin
          if (i_tx_done) begin
            advance    = 1'b1;
            next_state = START;
          end
          if (i_capture) begin
            set_overrun = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Scoreboard bench for three serializer configurations sharing one clock and reset.
module tb_fft_result_serializer;

  localparam int GAP = 5;

  logic         clk;
  logic         rst_n;
  logic         cap;
  logic         done;
  int           sel;
  int           vectors;
  int           miscompares;
  logic [7:0]   sb[$];

  logic [255:0] a_re, a_im;
  logic [63:0]  b_re, b_im;
  logic [23:0]  c_re, c_im;
  logic         a_cap, b_cap, c_cap, a_done, b_done, c_done;
  logic         a_start, b_start, c_start;
  logic [7:0]   a_byte, b_byte, c_byte;
  logic         a_busy, b_busy, c_busy;
  logic         a_fd, b_fd, c_fd;
  logic         a_ovr, b_ovr, c_ovr;

  logic         cur_start, cur_busy, cur_fd, cur_ovr;
  logic [7:0]   cur_byte;

  assign a_cap  = cap  && (sel == 0);
  assign b_cap  = cap  && (sel == 1);
  assign c_cap  = cap  && (sel == 2);
  assign a_done = done && (sel == 0);
  assign b_done = done && (sel == 1);
  assign c_done = done && (sel == 2);

  assign cur_start = (sel == 0) ? a_start : (sel == 1) ? b_start : c_start;
  assign cur_byte  = (sel == 0) ? a_byte  : (sel == 1) ? b_byte  : c_byte;
  assign cur_busy  = (sel == 0) ? a_busy  : (sel == 1) ? b_busy  : c_busy;
  assign cur_fd    = (sel == 0) ? a_fd    : (sel == 1) ? b_fd    : c_fd;
  assign cur_ovr   = (sel == 0) ? a_ovr   : (sel == 1) ? b_ovr   : c_ovr;

  fft_result_serializer u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_re_bus(a_re), .i_im_bus(a_im),
    .i_capture(a_cap), .i_tx_done(a_done), .o_tx_start(a_start), .o_tx_byte(a_byte),
    .o_busy(a_busy), .o_frame_done(a_fd), .o_overrun(a_ovr)
  );

  fft_result_serializer #(
    .FFT_SIZE(4), .WORD_SIZE(16), .INCLUDE_IM(1), .MSB_FIRST(1), .HEADER_EN(1), .HEADER_BYTE(8'hA5)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_re_bus(b_re), .i_im_bus(b_im),
    .i_capture(b_cap), .i_tx_done(b_done), .o_tx_start(b_start), .o_tx_byte(b_byte),
    .o_busy(b_busy), .o_frame_done(b_fd), .o_overrun(b_ovr)
  );

  fft_result_serializer #(
    .FFT_SIZE(2), .WORD_SIZE(12)
  ) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_re_bus(c_re), .i_im_bus(c_im),
    .i_capture(c_cap), .i_tx_done(c_done), .o_tx_start(c_start), .o_tx_byte(c_byte),
    .o_busy(c_busy), .o_frame_done(c_fd), .o_overrun(c_ovr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge, where inputs are driven and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle capture pulse; returns in the cycle where the first start is due.
  task automatic applyStimulus();
    cap = 1'b1;
    tick();
    cap = 1'b0;
  endtask

  // Default config: bins base+k, pushes LSB then MSB of each real word.
  task automatic setFrameA(input logic [15:0] base);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) begin
      w = base + 16'(k);
      a_re[k*16 +: 16] = w;
      sb.push_back(w[7:0]);
      sb.push_back(w[15:8]);
    end
  endtask

  // Serve count bytes with done GAP cycles after each start; optional overrun capture and coincident final capture.
  task automatic runFrame(input int count, input int total, input int ovr_at, input bit coincide);
    logic [7:0] exp_byte;
    bit         last;
    for (int i = 0; i < count; i++) begin
      checkOutput("tx_start", cur_start, 1);
      checkOutput("busy", cur_busy, 1);
      exp_byte = 8'h00;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL scoreboard_empty observed=start expected=no_byte_pending");
      end else begin
        exp_byte = sb.pop_front();
      end
      checkOutput("tx_byte", cur_byte, exp_byte);
      tick();
      checkOutput("start_one_cycle", cur_start, 0);
      for (int c = 1; c < GAP; c++) begin
        if (ovr_at == i && c == 2) cap = 1'b1;
        tick();
        cap = 1'b0;
      end
      checkOutput("byte_hold", cur_byte, exp_byte);
      if (ovr_at == i) checkOutput("overrun_set", cur_ovr, 1);
      last = (i == total - 1);
      done = 1'b1;
      if (last && coincide) cap = 1'b1;
      tick();
      done = 1'b0;
      cap  = 1'b0;
      checkOutput("frame_done", cur_fd, last);
      checkOutput("busy_after_done", cur_busy, (!last || coincide));
      if (last && !coincide) begin
        tick();
        checkOutput("frame_done_once", cur_fd, 0);
        checkOutput("idle_no_start", cur_start, 0);
      end
    end
  endtask

  // Directed sequence.
  initial begin
    logic [15:0] bw;
    logic [15:0] ext;
    logic [11:0] cw;
    logic [7:0]  exp_byte;
    vectors = 0;
    miscompares = 0;
    sel  = 0;
    cap  = 1'b0;
    done = 1'b0;
    rst_n = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; c_re = '0; c_im = '0;
    tick();
    tick();
    checkOutput("rst_start", a_start, 0);
    checkOutput("rst_byte", a_byte, 8'h00);
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_frame_done", a_fd, 0);
    checkOutput("rst_overrun", a_ovr, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] spurious done in idle");
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    checkOutput("idle_done_start", a_start, 0);
    checkOutput("idle_done_busy", a_busy, 0);

    $display("[TB] default frame, LSB first");
    setFrameA(16'h0100);
    applyStimulus();
    a_re = {8{$urandom}};
    runFrame(32, 32, -1, 1'b0);

    $display("[TB] capture coincident with final done");
    setFrameA(16'h0300);
    applyStimulus();
    setFrameA(16'h0400);
    runFrame(32, 32, -1, 1'b1);
    checkOutput("coincide_overrun", a_ovr, 0);

    $display("[TB] capture while busy at third byte");
    a_re = {8{$urandom}};
    runFrame(32, 32, 2, 1'b0);
    checkOutput("overrun_sticky", a_ovr, 1);

    $display("[TB] reset mid-frame at byte 10");
    setFrameA(16'h0500);
    applyStimulus();
    runFrame(10, 32, -1, 1'b0);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_busy", a_busy, 0);
    checkOutput("midrst_start", a_start, 0);
    checkOutput("midrst_byte", a_byte, 8'h00);
    checkOutput("midrst_overrun", a_ovr, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("postrst_start", a_start, 0);
    checkOutput("postrst_busy", a_busy, 0);
    sb.delete();

    $display("[TB] constant done during frame");
    setFrameA(16'h0600);
    done = 1'b1;
    applyStimulus();
    for (int i = 0; i < 32; i++) begin
      checkOutput("cd_start", a_start, 1);
      exp_byte = sb.pop_front();
      checkOutput("cd_byte", a_byte, exp_byte);
      tick();
      checkOutput("cd_gap", a_start, 0);
      tick();
    end
    checkOutput("cd_frame_done", a_fd, 1);
    checkOutput("cd_busy", a_busy, 0);
    tick();
    checkOutput("cd_idle_start", a_start, 0);
    checkOutput("cd_frame_done_once", a_fd, 0);
    done = 1'b0;

    $display("[TB] header, MSB first, with imaginary part");
    sel = 1;
    sb.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      b_re[k*16 +: 16] = 16'h1234;
      b_im[k*16 +: 16] = 16'hABCD;
      bw = b_re[k*16 +: 16];
      sb.push_back(bw[15:8]);
      sb.push_back(bw[7:0]);
      bw = b_im[k*16 +: 16];
      sb.push_back(bw[15:8]);
      sb.push_back(bw[7:0]);
    end
    applyStimulus();
    b_re = '0;
    runFrame(17, 17, -1, 1'b0);

    $display("[TB] 12-bit words, sign extension");
    sel = 2;
    c_re = {12'h07F, 12'h800};
    for (int k = 0; k < 2; k++) begin
      cw  = c_re[k*12 +: 12];
      ext = {{4{cw[11]}}, cw};
      sb.push_back(ext[7:0]);
      sb.push_back(ext[15:8]);
    end
    applyStimulus();
    runFrame(4, 4, -1, 1'b0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
